mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer_if.sv | 41 ++++
 rtl/mem_sequencer.sv | 132 +++++++++++++
 tb/tb_mem_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: request, completion and memory-side signals of the memory sequencer.
// Latency: none, wiring only.
// Backpressure: level requests held until done; memory stalls the sequencer through memReady.
interface mem_sequencer_if;
  // requester side
  logic       fetchReq;
  logic [7:0] fetchAddr;
  logic       dataReq;
  logic       dataWe;
  logic [7:0] dataAddr;
  logic [7:0] dataWrVal;
  logic       fetchDone;
  logic [7:0] fetchVal;
  logic       dataDone;
  logic [7:0] dataRdVal;
  logic       busy;
  logic       err;
  // memory side
  logic       memReady;
  logic [7:0] memRdVal;
  logic [7:0] memAddr;
  logic [7:0] memWrVal;
  logic       memRd;
  logic       memWr;

  // sequencer view
  modport slave (
    input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWrVal,
    input  memReady, memRdVal,
    output memAddr, memWrVal, memRd, memWr,
    output fetchDone, fetchVal, dataDone, dataRdVal, busy, err
  );

  // requester/memory environment view
  modport master (
    output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWrVal,
    output memReady, memRdVal,
    input  memAddr, memWrVal, memRd, memWr,
    input  fetchDone, fetchVal, dataDone, dataRdVal, busy, err
  );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: round-robin arbiter/sequencer of fetch and load/store onto one memory port.
// Latency: 2 cycles request-sampled to done pulse with memReady on the first access cycle.
// Backpressure: requests are level-held until done; memReady stalls, bounded by TIMEOUT.
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // everything the access needs, frozen at grant time so requester
  // inputs may wander while the access is in flight
  typedef struct packed {
    logic       is_fetch;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wval;
  } req_t;

  // counter value seen on the last allowed ACCESS cycle
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;

  req_t       grant_req;
  logic       grant_vld;
  logic       grant_fetch;
  req_t       cur_req;
  logic       last_fetch;   // 1: fetch was granted last, 0: data was

  logic [7:0] cnt;
  logic       mem_hit;
  logic       time_out;
  logic       finish;
  logic [7:0] cap_val;

  logic [7:0] fetch_val_q;
  logic [7:0] data_val_q;
  logic       err_q;

  // arbitration: single requester wins outright, a tie goes to the one not granted last
  always_comb begin
    grant_vld          = bus.fetchReq | bus.dataReq;
    grant_fetch        = bus.fetchReq & (~bus.dataReq | ~last_fetch);
    grant_req.is_fetch = grant_fetch;
    grant_req.we       = ~grant_fetch & bus.dataWe;
    grant_req.addr     = grant_fetch ? bus.fetchAddr : bus.dataAddr;
    grant_req.wval     = grant_fetch ? 8'h00 : bus.dataWrVal;
  end

  // access termination: memory answer wins over a timeout landing on the same cycle
  always_comb begin
    mem_hit  = (state == ACCESS) & bus.memReady;
    time_out = (state == ACCESS) & ~bus.memReady & (cnt == CNT_LAST);
    finish   = mem_hit | time_out;
    cap_val  = mem_hit ? bus.memRdVal : 8'h00;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; requests only matter in IDLE, memReady only in ACCESS
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  if (finish)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant latch, access-cycle counter, result capture and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_req     <= '0;
      last_fetch  <= 1'b0;
      cnt         <= 8'h00;
      fetch_val_q <= 8'h00;
      data_val_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      if (state == IDLE && grant_vld) begin
        cur_req    <= grant_req;
        last_fetch <= grant_fetch;
        cnt        <= 8'h00;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 8'd1;
      end
      if (finish && !cur_req.we) begin
        if (cur_req.is_fetch) begin
          fetch_val_q <= cap_val;
        end else begin
          data_val_q <= cap_val;
        end
      end
      if (time_out) begin
        err_q <= 1'b1;
      end
    end
  end

  // memory strobes exist only in ACCESS; done pulses only in DONE
  always_comb begin
    bus.memAddr   = cur_req.addr;
    bus.memWrVal  = cur_req.wval;
    bus.memRd     = (state == ACCESS) & ~cur_req.we;
    bus.memWr     = (state == ACCESS) &  cur_req.we;
    bus.fetchDone = (state == DONE) &  cur_req.is_fetch;
    bus.dataDone  = (state == DONE) & ~cur_req.is_fetch;
    bus.fetchVal  = fetch_val_q;
    bus.dataRdVal = data_val_q;
    bus.busy      = (state != IDLE);
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: randomized stimulus with a queue scoreboard against a transaction-level model.
// Latency: n/a.
// Backpressure: the bench memory inserts a chosen number of wait cycles per access.
`timescale 1ns/1ps
module tb_mem_sequencer;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sequencer_if bus();

  mem_sequencer #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         fetch;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wval;
    int         strobes;
    logic [7:0] fv;
    logic [7:0] dv;
    bit         err;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  logic [7:0] mem_array [256];   // the memory the bench plays
  logic [7:0] ref_mem   [256];   // the model's idea of that memory
  logic [7:0] ref_fv, ref_dv;
  bit         ref_err, ref_last_fetch;
  int         mem_delay = 0;
  int         mem_n = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level reference: outcome decided by wait cycles vs timeout
  task automatic predict(bit f, bit we, logic [7:0] addr, logic [7:0] wval, int delay);
    exp_t e;
    e.fetch = f;
    e.we    = f ? 1'b0 : we;
    e.addr  = addr;
    e.wval  = wval;
    if (delay < TO) begin
      e.strobes = delay + 1;
      if (f)        ref_fv = ref_mem[addr];
      else if (!we) ref_dv = ref_mem[addr];
      else          ref_mem[addr] = wval;
    end else begin
      e.strobes = TO;
      ref_err   = 1'b1;
      if (f)        ref_fv = 8'h00;
      else if (!we) ref_dv = 8'h00;
    end
    e.fv  = ref_fv;
    e.dv  = ref_dv;
    e.err = ref_err;
    ref_last_fetch = f;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    ref_fv = 8'h00;
    ref_dv = 8'h00;
    ref_err = 1'b0;
    ref_last_fetch = 1'b0;
  endtask

  // bench memory: answers on the (mem_delay+1)-th strobe cycle, noise on memReady otherwise
  always @(negedge clk) begin
    if (bus.memRd || bus.memWr) begin
      mem_n = mem_n + 1;
      if (mem_n == mem_delay + 1) begin
        bus.memReady = 1'b1;
        bus.memRdVal = mem_array[bus.memAddr];
        if (bus.memWr) mem_array[bus.memAddr] = bus.memWrVal;
      end else begin
        bus.memReady = 1'b0;
        bus.memRdVal = 8'($urandom);
      end
    end else begin
      mem_n = 0;
      bus.memReady = 1'($urandom);
      bus.memRdVal = 8'($urandom);
    end
  end

  // monitor: checks every strobe cycle and pops the scoreboard on each done pulse
  int strobe_cnt = 0;
  bit prev_strobe = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    logic strobe;
    strobe = bus.memRd | bus.memWr;
    if (rst) begin
      if (strobe) begin
        check("rd_wr_exclusive", 32'(bus.memRd & bus.memWr), 0);
        strobe_cnt = prev_strobe ? strobe_cnt + 1 : 1;
        if (exp_q.size() > 0) begin
          check("mem_addr", bus.memAddr, exp_q[0].addr);
          check("mem_wr", 32'(bus.memWr), 32'(exp_q[0].we));
          if (exp_q[0].we) check("mem_wr_val", bus.memWrVal, exp_q[0].wval);
        end
      end
      if (bus.fetchDone || bus.dataDone) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", {30'd0, bus.fetchDone, bus.dataDone}, e.fetch ? 32'd2 : 32'd1);
          check("done_after_access", 32'(prev_strobe), 1);
          check("strobe_cycles", strobe_cnt, e.strobes);
          check("fetch_val", bus.fetchVal, e.fv);
          check("data_rd_val", bus.dataRdVal, e.dv);
          check("err", 32'(bus.err), 32'(e.err));
        end
      end
    end
    prev_strobe = strobe;
  end

  // single request, held until its done pulse; inputs scrambled after grant
  task automatic do_access(bit f, bit we, logic [7:0] addr, logic [7:0] wval, int delay);
    bit done;
    @(negedge clk);
    mem_delay = delay;
    predict(f, we, addr, wval, delay);
    if (f) begin
      bus.fetchReq  = 1'b1;
      bus.fetchAddr = addr;
    end else begin
      bus.dataReq   = 1'b1;
      bus.dataWe    = we;
      bus.dataAddr  = addr;
      bus.dataWrVal = wval;
    end
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.fetchDone || bus.dataDone) begin
        done = 1'b1;
      end else begin
        bus.fetchAddr = 8'($urandom);
        bus.dataAddr  = 8'($urandom);
        bus.dataWrVal = 8'($urandom);
      end
    end
    if (!done) check("wait_done", 0, 1);
    bus.fetchReq = 1'b0;
    bus.dataReq  = 1'b0;
  endtask

  task automatic rand_batch(int n, int maxd);
    bit f, we;
    for (int i = 0; i < n; i++) begin
      f  = 1'($urandom);
      we = 1'($urandom);
      do_access(f, we, 8'($urandom_range(15, 0)), 8'($urandom), int'($urandom_range(maxd, 0)));
    end
  endtask

  // both requests held with an always-ready memory: grants must alternate
  task automatic both_held(int n);
    logic [7:0] fa, da;
    bit nf;
    int seen;
    @(negedge clk);
    mem_delay = 0;
    fa = 8'($urandom_range(15, 0));
    da = 8'($urandom_range(15, 0));
    nf = !ref_last_fetch;
    for (int k = 0; k < n; k++) begin
      predict(nf, 1'b0, nf ? fa : da, 8'h00, 0);
      nf = !nf;
    end
    bus.fetchAddr = fa;
    bus.dataAddr  = da;
    bus.dataWe    = 1'b0;
    bus.fetchReq  = 1'b1;
    bus.dataReq   = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 * n && seen < n; i++) begin
      @(negedge clk);
      if (bus.fetchDone || bus.dataDone) seen++;
    end
    if (seen < n) check("wait_both_done", seen, n);
    bus.fetchReq = 1'b0;
    bus.dataReq  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem_array[a] = 8'($urandom);
      ref_mem[a]   = mem_array[a];
    end
    mem_array[8'h05] = 8'h3A;
    ref_mem[8'h05]   = 8'h3A;
    model_reset();

    rst = 1'b0;
    bus.fetchReq = 1'b0; bus.fetchAddr = 8'h00;
    bus.dataReq  = 1'b0; bus.dataWe    = 1'b0;
    bus.dataAddr = 8'h00; bus.dataWrVal = 8'h00;
    bus.memReady = 1'b0; bus.memRdVal  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_memRd", 32'(bus.memRd), 0);
    check("rst_memWr", 32'(bus.memWr), 0);
    check("rst_fetchDone", 32'(bus.fetchDone), 0);
    check("rst_dataDone", 32'(bus.dataDone), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_fetchVal", bus.fetchVal, 0);
    check("rst_dataRdVal", bus.dataRdVal, 0);
    check("rst_memAddr", bus.memAddr, 0);
    check("rst_memWrVal", bus.memWrVal, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // first tie goes to fetch, then strict alternation
    both_held(6);
    // single fetch with immediate ready; store with three wait cycles
    do_access(1'b1, 1'b0, 8'h05, 8'h00, 0);
    do_access(1'b0, 1'b1, 8'h10, 8'hC3, 3);
    do_access(1'b0, 1'b0, 8'h10, 8'h00, 1);
    rand_batch(20, TO - 1);
    // timed-out load, then error must stay sticky through good and bad accesses
    do_access(1'b0, 1'b0, 8'h22, 8'h00, TO + 2);
    rand_batch(20, TO + 1);
    both_held(4);

    // reset on the second ACCESS cycle of a load aborts it silently
    @(negedge clk);
    mem_delay = 10;
    predict(1'b0, 1'b0, 8'h07, 8'h00, 10);
    bus.dataWe = 1'b0; bus.dataAddr = 8'h07; bus.dataReq = 1'b1;
    for (int i = 0; i < 20 && !bus.memRd; i++) @(negedge clk);
    check("abort_first_access", 32'(bus.memRd), 1);
    @(negedge clk);
    rst = 1'b0;
    bus.dataReq = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("abort_memRd", 32'(bus.memRd), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_err", 32'(bus.err), 0);
    check("abort_dataDone", 32'(bus.dataDone), 0);
    check("abort_dataRdVal", bus.dataRdVal, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(bus.dataDone | bus.fetchDone), 0);
    end
    do_access(1'b0, 1'b0, 8'h07, 8'h00, 1);
    rand_batch(10, TO - 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
